// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, commit codes, ExcCodes, bit positions.
// Consumed by the CP0 register file and the memory-stage exception unit.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;
    localparam logic [4:0] EXCCODE_TR   = 5'h0d;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    function automatic logic [4:0] exc_code(input logic [31:0] t);
        logic [4:0] c;
        c = t[4:0];
        case (t)
            EXC_INT:  c = EXCCODE_INT;
            EXC_ADEL: c = EXCCODE_ADEL;
            EXC_ADES: c = EXCCODE_ADES;
            EXC_SYS:  c = EXCCODE_SYS;
            EXC_BP:   c = EXCCODE_BP;
            EXC_RI:   c = EXCCODE_RI;
            EXC_OV:   c = EXCCODE_OV;
            EXC_TR:   c = EXCCODE_TR;
            default:  c = t[4:0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// CP0 access bundle: MTC0/MFC0, commit verdict, interrupt lines, live outputs.
// master = core side, slave = CP0 register file.
interface cp0_regfile_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] except_type_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] badvaddr_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, int_i,
        output except_type_i, pc_i, is_in_delayslot_i, badvaddr_i,
        input  rdata_o, status_o, cause_o, epc_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, int_i,
        input  except_type_i, pc_i, is_in_delayslot_i, badvaddr_i,
        output rdata_o, status_o, cause_o, epc_o, timer_int_o
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, TI latches on match.
// Only built when CP0_TIMER_EN is defined.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic toggle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            toggle <= 1'b0;
        end else if (count_we) begin
            count  <= wdata;
            toggle <= 1'b0;
        end else begin
            toggle <= ~toggle;
            if (toggle) count <= count + 32'd1;
        end
    end

    // Compare write clears TI even if this cycle also matches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare <= '0;
            ti      <= 1'b0;
        end else if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
        end else if (count == compare) begin
            ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: exception commit, MTC0/MFC0, interrupt sampling.
// Define CP0_TIMER_EN to build the Count/Compare timer (cp0_timer).
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h8000_0000
) (
    input logic         clk,
    input logic         rst,
    cp0_regfile_if.slave bus
);

    logic [31:0] badvaddr;
    logic [31:0] epc;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    logic exc_commit;
    logic eret;
    logic mtc0;

    assign exc_commit = (bus.except_type_i != EXC_NONE) &&
                        (bus.except_type_i != EXC_ERET);
    assign eret = (bus.except_type_i == EXC_ERET);
    assign mtc0 = bus.we_i && !exc_commit && !eret;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0 && (bus.waddr_i == CP0_COUNT)),
        .compare_we (mtc0 && (bus.waddr_i == CP0_COMPARE)),
        .wdata      (bus.wdata_i),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cause_ip_hw <= '0;
        end else begin
            cause_ip_hw <= {bus.int_i[5] | ti, bus.int_i[4:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr    <= '0;
            epc         <= '0;
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ip_sw <= '0;
            cause_exc   <= '0;
        end else if (exc_commit) begin
            status_exl <= 1'b1;
            cause_exc  <= exc_code(bus.except_type_i);
            // Nested exception keeps the original return point
            if (!status_exl) begin
                epc      <= bus.is_in_delayslot_i ? bus.pc_i - 32'd4
                                                  : bus.pc_i;
                cause_bd <= bus.is_in_delayslot_i;
            end
            if (bus.except_type_i == EXC_ADEL ||
                bus.except_type_i == EXC_ADES) begin
                badvaddr <= bus.badvaddr_i;
            end
        end else if (eret) begin
            status_exl <= 1'b0;
        end else if (mtc0) begin
            case (bus.waddr_i)
                CP0_STATUS: begin
                    status_im  <= bus.wdata_i[15:8];
                    status_exl <= bus.wdata_i[STATUS_EXL];
                    status_ie  <= bus.wdata_i[STATUS_IE];
                end
                CP0_CAUSE: cause_ip_sw <= bus.wdata_i[9:8];
                CP0_EPC:   epc         <= bus.wdata_i;
                default:   ;
            endcase
        end
    end

    logic [31:0] status_w;
    logic [31:0] cause_w;
    logic [31:0] rdata;

    assign status_w = {9'b0, 1'b1, 6'b0, status_im, 6'b0,
                       status_exl, status_ie};
    assign cause_w  = {cause_bd, ti, 14'b0, cause_ip_hw, cause_ip_sw,
                       1'b0, cause_exc, 2'b0};

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            bus.raddr_i == CP0_BADVADDR: rdata = badvaddr;
            bus.raddr_i == CP0_COUNT:    rdata = count;
            bus.raddr_i == CP0_COMPARE:  rdata = compare;
            bus.raddr_i == CP0_STATUS:   rdata = status_w;
            bus.raddr_i == CP0_CAUSE:    rdata = cause_w;
            bus.raddr_i == CP0_EPC:      rdata = epc;
            bus.raddr_i == CP0_PRID:     rdata = PRID_VAL;
            bus.raddr_i == CP0_CONFIG:   rdata = CONFIG_VAL;
            default:                     rdata = '0;
        endcase
    end

    assign bus.rdata_o     = rdata;
    assign bus.status_o    = status_w;
    assign bus.cause_o     = cause_w;
    assign bus.epc_o       = epc;
    assign bus.timer_int_o = ti;

endmodule
